// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the shift arbiter: op encodings, FSM states, default widths.
package shift_arbiter_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Maps the recorded owner index onto the pair of response-valid bits.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer picks the winner only when both request.
module rr_arb2
    import shift_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_r;

    // One-hot grant: lone requester wins outright, contention resolved by pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer flips on every accepted request, so contention alternates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= ~ptr_r;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one external barrel shifter between the ALU (requester 0) and multdiv (requester 1).
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic             r0_op,
    input  logic [SHW-1:0]   r0_shamt,
    input  logic [WIDTH-1:0] r0_data,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic             r1_op,
    input  logic [SHW-1:0]   r1_shamt,
    input  logic [WIDTH-1:0] r1_data,
    output logic [WIDTH-1:0] sh_data,
    output logic [SHW-1:0]   sh_shamt,
    output logic             sh_op,
    input  logic [WIDTH-1:0] sh_result,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic             busy
);

    state_e           state_r;
    logic             owner_r;
    logic [WIDTH-1:0] sh_data_r;
    logic [SHW-1:0]   sh_shamt_r;
    logic             sh_op_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic [1:0]       rsp_valid_r;
    logic             busy_r;

    logic [1:0]       gnt_s;
    logic             idle_s;
    logic             accept_s;
    logic             rsp_ready_s;

    assign idle_s   = (state_r == ST_IDLE);
    assign accept_s = idle_s && (gnt_s != 2'b00);

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     ({r1_valid, r0_valid}),
        .advance (accept_s),
        .gnt     (gnt_s)
    );

    // Ready is only offered while idle, so nothing is accepted mid-transaction.
    assign r0_ready    = idle_s && gnt_s[0];
    assign r1_ready    = idle_s && gnt_s[1];
    assign rsp_ready_s = owner_r ? rsp1_ready : rsp0_ready;

    // Transaction FSM: latch request, give the shifter one cycle, then hold the result until consumed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b0;
            sh_data_r   <= {WIDTH{1'b0}};
            sh_shamt_r  <= {SHW{1'b0}};
            sh_op_r     <= OP_SLL;
            rsp_data_r  <= {WIDTH{1'b0}};
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r    <= gnt_s[1];
                        sh_op_r    <= gnt_s[1] ? r1_op    : r0_op;
                        sh_shamt_r <= gnt_s[1] ? r1_shamt : r0_shamt;
                        sh_data_r  <= gnt_s[1] ? r1_data  : r0_data;
                        busy_r     <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    rsp_data_r  <= sh_result;
                    rsp_valid_r <= owner_onehot(owner_r);
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_s) begin
                        rsp_valid_r <= 2'b00;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 2'b00;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign sh_data    = sh_data_r;
    assign sh_shamt   = sh_shamt_r;
    assign sh_op      = sh_op_r;
    assign rsp_data   = rsp_data_r;
    assign rsp0_valid = rsp_valid_r[0];
    assign rsp1_valid = rsp_valid_r[1];
    assign busy       = busy_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural model of the external barrel shifter.
module tb_shift_arbiter;

    logic        clock;
    logic        reset;
    logic        r0_valid, r0_ready, r0_op;
    logic [4:0]  r0_shamt;
    logic [31:0] r0_data;
    logic        r1_valid, r1_ready, r1_op;
    logic [4:0]  r1_shamt;
    logic [31:0] r1_data;
    logic [31:0] sh_data;
    logic [4:0]  sh_shamt;
    logic        sh_op;
    logic [31:0] sh_result;
    logic [31:0] rsp_data;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_arbiter #(.WIDTH(32), .SHW(5)) dut (
        .clock(clock), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_shamt(r0_shamt), .r0_data(r0_data),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_shamt(r1_shamt), .r1_data(r1_data),
        .sh_data(sh_data), .sh_shamt(sh_shamt), .sh_op(sh_op), .sh_result(sh_result),
        .rsp_data(rsp_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External shifter: SLL or SRA, purely combinational.
    always_comb begin
        if (sh_op) sh_result = $signed(sh_data) >>> sh_shamt;
        else       sh_result = sh_data << sh_shamt;
    end

    task automatic wait_grant(input int idx, input int max, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clock);
            if ((idx == 1) ? r1_ready : r0_ready) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int idx, input int max, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clock);
            if ((idx == 1) ? rsp1_valid : rsp0_valid) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        r0_valid = 1'b0; r0_op = 1'b0; r0_shamt = 5'd0; r0_data = 32'h0;
        r1_valid = 1'b0; r1_op = 1'b0; r1_shamt = 5'd0; r1_data = 32'h0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clock);
        checks++; if (sh_data !== 32'h0)   begin errors++; $display("FAIL reset_sh_data got %h exp 0", sh_data); end
        checks++; if (sh_shamt !== 5'd0)   begin errors++; $display("FAIL reset_sh_shamt got %0d exp 0", sh_shamt); end
        checks++; if (sh_op !== 1'b0)      begin errors++; $display("FAIL reset_sh_op got %b exp 0", sh_op); end
        checks++; if (rsp_data !== 32'h0)  begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        checks++; if ({rsp1_valid, rsp0_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_valids_busy got %b exp 000", {rsp1_valid, rsp0_valid, busy});
        end
        checks++; if ({r1_ready, r0_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b exp 00", {r1_ready, r0_ready});
        end
        @(posedge clock); #1;
    endtask

    task automatic test_sll_r0();
        r0_valid = 1'b1; r0_op = 1'b0; r0_shamt = 5'd31; r0_data = 32'h0000_0001;
        rsp0_ready = 1'b1;
        @(negedge clock);
        checks++; if ({r1_ready, r0_ready} !== 2'b01) begin
            errors++; $display("FAIL sll_grant got %b exp 01", {r1_ready, r0_ready});
        end
        @(posedge clock); #1;
        r0_valid = 1'b0; r0_data = 32'hFFFF_FFFF; r0_shamt = 5'd3;
        @(negedge clock);
        checks++; if ({busy, rsp0_valid, sh_data, sh_shamt} !== {1'b1, 1'b0, 32'h1, 5'd31}) begin
            errors++; $display("FAIL sll_issue got busy=%b v=%b d=%h s=%0d exp 1 0 00000001 31",
                               busy, rsp0_valid, sh_data, sh_shamt);
        end
        @(negedge clock);
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
            errors++; $display("FAIL sll_rsp_valid got %b exp 10", {rsp0_valid, rsp1_valid});
        end
        checks++; if (rsp_data !== 32'h8000_0000) begin
            errors++; $display("FAIL sll_rsp_data got %h exp 80000000", rsp_data);
        end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if ({rsp0_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL sll_done got %b exp 00", {rsp0_valid, busy});
        end
        @(posedge clock); #1;
    endtask

    task automatic test_sra_r1();
        logic [31:0] din [2];
        logic [31:0] dexp [2];
        bit ok;
        int n;
        din[0] = 32'h8000_0000; dexp[0] = 32'hF800_0000;
        din[1] = 32'h7FFF_FFF0; dexp[1] = 32'h07FF_FFFF;
        rsp1_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            r1_valid = 1'b1; r1_op = 1'b1; r1_shamt = 5'd4; r1_data = din[k];
            wait_grant(1, 5, ok, n);
            checks++; if (!ok) begin errors++; $display("FAIL sra_grant%0d got none exp grant", k); end
            @(posedge clock); #1;
            r1_valid = 1'b0;
            wait_rsp(1, 6, ok, n);
            checks++; if (!ok || n != 2) begin
                errors++; $display("FAIL sra_latency%0d got ok=%b n=%0d exp n=2", k, ok, n);
            end
            checks++; if ({rsp_data, rsp0_valid} !== {dexp[k], 1'b0}) begin
                errors++; $display("FAIL sra_data%0d got %h r0v=%b exp %h 0", k, rsp_data, rsp0_valid, dexp[k]);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_contention();
        int got = 0;
        bit viol = 1'b0;
        apply_reset();
        r0_valid = 1'b1; r0_op = 1'b0; r0_shamt = 5'd1; r0_data = 32'h0000_0003;
        r1_valid = 1'b1; r1_op = 1'b1; r1_shamt = 5'd2; r1_data = 32'hF000_0000;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clock);
            if (busy && (r0_ready || r1_ready)) viol = 1'b1;
            if (rsp0_valid || rsp1_valid) begin
                checks++; if ({rsp1_valid, rsp0_valid} !== ((got % 2 == 1) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL contention_order%0d got %b exp %b", got,
                                       {rsp1_valid, rsp0_valid}, (got % 2 == 1) ? 2'b10 : 2'b01);
                end
                checks++; if (rsp_data !== ((got % 2 == 1) ? 32'hFC00_0000 : 32'h0000_0006)) begin
                    errors++; $display("FAIL contention_data%0d got %h exp %h", got, rsp_data,
                                       (got % 2 == 1) ? 32'hFC00_0000 : 32'h0000_0006);
                end
                got++;
            end
            if (got < 4) begin
                @(posedge clock); #1;
            end
        end
        checks++; if (got != 4) begin errors++; $display("FAIL contention_count got %0d exp 4", got); end
        checks++; if (viol) begin errors++; $display("FAIL contention_ready_busy got 1 exp 0"); end
        @(posedge clock); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_hold();
        bit ok;
        int n;
        r0_valid = 1'b1; r0_op = 1'b0; r0_shamt = 5'd0; r0_data = 32'h1234_5678;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        wait_grant(0, 5, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL hold_grant got none exp grant"); end
        @(posedge clock); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_op = 1'b0; r1_shamt = 5'd4; r1_data = 32'h0000_0001;
        wait_rsp(0, 6, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL hold_rsp got none exp rsp0_valid"); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            checks++; if ({rsp0_valid, busy, r1_ready, rsp_data} !== {1'b1, 1'b1, 1'b0, 32'h1234_5678}) begin
                errors++; $display("FAIL hold_stable%0d got v=%b b=%b r1r=%b d=%h exp 1 1 0 12345678",
                                   i, rsp0_valid, busy, r1_ready, rsp_data);
            end
            @(posedge clock); #1;
        end
        rsp0_ready = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if ({rsp0_valid, busy, r1_ready} !== 3'b001) begin
            errors++; $display("FAIL hold_release got %b exp 001", {rsp0_valid, busy, r1_ready});
        end
        @(posedge clock); #1;
        r1_valid = 1'b0;
        wait_rsp(1, 6, ok, n);
        checks++; if (!ok || rsp_data !== 32'h0000_0010) begin
            errors++; $display("FAIL hold_r1_result got ok=%b d=%h exp 00000010", ok, rsp_data);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        r1_valid = 1'b1; r1_op = 1'b1; r1_shamt = 5'd1; r1_data = 32'h8000_0005;
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        wait_grant(1, 5, ok, n);
        @(posedge clock); #1;
        r1_valid = 1'b0;
        wait_rsp(1, 6, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_rsp got none exp rsp1_valid"); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({rsp1_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL midrst_valid_busy got %b exp 00", {rsp1_valid, busy});
        end
        checks++; if ({sh_data, sh_shamt, sh_op} !== {32'h0, 5'd0, 1'b0}) begin
            errors++; $display("FAIL midrst_sh got d=%h s=%0d o=%b exp 0 0 0", sh_data, sh_shamt, sh_op);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        rsp1_ready = 1'b1;
        r0_valid = 1'b1; r0_op = 1'b0; r0_shamt = 5'd2; r0_data = 32'h0000_0001;
        r1_valid = 1'b1; r1_op = 1'b0; r1_shamt = 5'd3; r1_data = 32'h0000_0001;
        @(negedge clock);
        checks++; if ({r1_ready, r0_ready, rsp1_valid} !== 3'b010) begin
            errors++; $display("FAIL midrst_first_grant got %b exp 010", {r1_ready, r0_ready, rsp1_valid});
        end
        @(posedge clock); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        wait_rsp(0, 6, ok, n);
        checks++; if (!ok || rsp_data !== 32'h0000_0004) begin
            errors++; $display("FAIL midrst_result got ok=%b d=%h exp 00000004", ok, rsp_data);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] dexp [3];
        bit ok;
        int n;
        dexp[0] = 32'h2; dexp[1] = 32'h4; dexp[2] = 32'h8;
        rsp1_ready = 1'b1;
        r1_valid = 1'b1; r1_op = 1'b0; r1_shamt = 5'd1; r1_data = 32'h0000_0001;
        for (int k = 0; k < 3; k++) begin
            wait_grant(1, 5, ok, n);
            checks++; if (!ok || n != 1) begin
                errors++; $display("FAIL b2b_grant%0d got ok=%b wait=%0d exp wait=1", k, ok, n);
            end
            @(posedge clock); #1;
            if (k == 2) r1_valid = 1'b0;
            r1_shamt = 5'(k + 2);
            wait_rsp(1, 6, ok, n);
            checks++; if (!ok || rsp_data !== dexp[k]) begin
                errors++; $display("FAIL b2b_result%0d got ok=%b d=%h exp %h", k, ok, rsp_data, dexp[k]);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        test_reset();
        test_sll_r0();
        test_sra_r1();
        test_contention();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
